// File: rtl/fpu_split_ctl.sv
// Control glue for a split high/low FPU: per-port op tracking pipeline, XADD chain
// generation, FUS selection, retire merging with collision detection and retire counting.
module fpu_split_ctl #(
   parameter int NPORT = 3,
   parameter int LAT = 4,
   parameter int OPW = 21,
   parameter int RETW = 14,
   parameter int FUSW = 6,
   parameter logic [7:0] CMPDH_OP = 8'h4C,
   parameter int CNTW = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NPORT-1:0]        in_en,
   input  logic [NPORT*OPW-1:0]    in_op,
   input  logic [NPORT-1:0]        in_xadd,
   input  logic                    stall,
   input  logic                    flush,
   output logic [NPORT-1:0]        xadd_chain,
   input  logic [NPORT*FUSW-1:0]   fus_hi,
   input  logic [NPORT*FUSW-1:0]   fus_lo,
   output logic [NPORT*FUSW-1:0]   fus_out,
   input  logic [NPORT*RETW-1:0]   ret_hi,
   input  logic [NPORT-1:0]        ret_en_hi,
   input  logic [NPORT*RETW-1:0]   ret_lo,
   input  logic [NPORT-1:0]        ret_en_lo,
   output logic [NPORT*RETW-1:0]   ret_out,
   output logic [NPORT-1:0]        ret_en_out,
   input  logic                    err_clr,
   output logic [NPORT-1:0]        err,
   output logic [NPORT*CNTW-1:0]   ret_cnt,
   output logic                    busy
);

   logic [NPORT*LAT-1:0] vld_all;

   assign busy = |vld_all;

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      // Index 0 is stage s1, index LAT-1 is stage sLAT.
      logic [LAT-1:0] vld;
      logic [LAT-1:0] xadd;
      logic [OPW-1:0] op [LAT];
      logic [RETW-1:0] ret_q;
      logic            ret_en_q;
      logic            err_q;
      logic [CNTW-1:0] cnt_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            vld  <= '0;
            xadd <= '0;
            for (int k = 0; k < LAT; k++) op[k] <= '0;
         end else if (flush) begin
            vld <= '0;
         end else if (!stall) begin
            vld    <= {vld[LAT-2:0], in_en[p]};
            xadd   <= {xadd[LAT-2:0], in_xadd[p]};
            op[0]  <= in_op[p*OPW +: OPW];
            for (int k = 1; k < LAT; k++) op[k] <= op[k-1];
         end
      end

      // Retire merge ignores stall/flush: each half kills its own results.
      always_ff @(posedge clk) begin
         if (rst) begin
            ret_q    <= '0;
            ret_en_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
         end else begin
            ret_en_q <= ret_en_hi[p] | ret_en_lo[p];
            ret_q    <= (ret_hi[p*RETW +: RETW] & {RETW{ret_en_hi[p]}})
                      | (ret_lo[p*RETW +: RETW] & {RETW{ret_en_lo[p]}});
            if (ret_en_hi[p] && ret_en_lo[p]) err_q <= 1'b1;
            else if (err_clr)                 err_q <= 1'b0;
            if (ret_en_q) cnt_q <= cnt_q + 1'b1;
         end
      end

      assign vld_all[p*LAT +: LAT]   = vld;
      assign xadd_chain[p]           = vld[LAT-2] & ~xadd[LAT-2] & op[LAT-2][10];
      assign fus_out[p*FUSW +: FUSW] = (vld[LAT-1] && (op[LAT-1][7:0] == CMPDH_OP))
                                       ? fus_hi[p*FUSW +: FUSW] : fus_lo[p*FUSW +: FUSW];
      assign ret_out[p*RETW +: RETW] = ret_q;
      assign ret_en_out[p]           = ret_en_q;
      assign err[p]                  = err_q;
      assign ret_cnt[p*CNTW +: CNTW] = cnt_q;
   end

endmodule
